// File: rtl/mem_req_master.sv
// mem_req_master: initiator for the 16-word x 32-bit valid/ready memory interface.
// Client commands are queued in a small FIFO. The head is driven onto the slave
// interface and held until the slave accepts it. Each completion is reported on a
// one-cycle response port. A sticky flag records a slave that stalls too long.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no request outstanding; loads the FIFO head as soon as one exists
//   REQ   | req_* driven and frozen until req_ready_i; chains the next command
module mem_req_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    input  logic        cmd_rnw_i,
    input  logic [3:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        cmd_ready_o,
    output logic        req_o,
    output logic        req_rnw_o,
    output logic [3:0]  req_addr_o,
    output logic [31:0] req_wdata_o,
    input  logic        req_ready_i,
    input  logic [31:0] req_rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_rnw_o,
    output logic [3:0]  rsp_addr_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        err_timeout_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int EW = 37;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state;
    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   wait_cnt;
    logic [EW-1:0]   head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            handshake;

    // Ready depends only on registered FIFO state, so a full FIFO never
    // accepts a command even if the head leaves in the same cycle.
    assign fifo_full   = (count == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign cmd_ready_o = !fifo_full && !rst;
    assign push        = cmd_valid_i && cmd_ready_o;

    // req_o is only ever high in REQ; the state term keeps ready ignored in IDLE.
    assign handshake   = (state == REQ) && req_o && req_ready_i;

    // The head is consumed whenever the request register is free at this edge:
    // either nothing is outstanding, or the outstanding request completes now.
    assign pop         = !fifo_empty && ((state == IDLE) || handshake);
    assign head        = fifo_mem[rd_ptr];

    assign busy_o      = req_o || !fifo_empty;

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_rnw_i, cmd_addr_i, cmd_wdata_i};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Request FSM, response capture and stall watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            req_o         <= 1'b0;
            req_rnw_o     <= 1'b0;
            req_addr_o    <= '0;
            req_wdata_o   <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rnw_o     <= 1'b0;
            rsp_addr_o    <= '0;
            rsp_rdata_o   <= '0;
            wait_cnt      <= '0;
            err_timeout_o <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (handshake) begin
                rsp_valid_o <= 1'b1;
                rsp_rnw_o   <= req_rnw_o;
                rsp_addr_o  <= req_addr_o;
                rsp_rdata_o <= req_rnw_o ? req_rdata_i : 32'd0;
            end

            // A new request gets a fresh stall budget.
            if (pop) begin
                req_rnw_o   <= head[36];
                req_addr_o  <= head[35:32];
                req_wdata_o <= head[31:0];
                wait_cnt    <= '0;
            end

            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= REQ;
                        req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (req_ready_i) begin
                        if (fifo_empty) begin
                            state <= IDLE;
                            req_o <= 1'b0;
                        end
                    end else begin
                        // The request stays up after a timeout; only the flag records it.
                        if (wait_cnt != TW'(TIMEOUT)) begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                        if (wait_cnt == TW'(TIMEOUT - 1)) begin
                            err_timeout_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Self-checking bench for mem_req_master: scripted slave, scoreboard queues,
// reference memory model and a cycle-level timeout model.
module tb_mem_req_master;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i;
    logic        cmd_rnw_i;
    logic [3:0]  cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        cmd_ready_o;
    logic        req_o;
    logic        req_rnw_o;
    logic [3:0]  req_addr_o;
    logic [31:0] req_wdata_o;
    logic        req_ready_i;
    logic [31:0] req_rdata_i;
    logic        rsp_valid_o;
    logic        rsp_rnw_o;
    logic [3:0]  rsp_addr_o;
    logic [31:0] rsp_rdata_o;
    logic        busy_o;
    logic        err_timeout_o;

    mem_req_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_rnw_i     (cmd_rnw_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_ready_o   (cmd_ready_o),
        .req_o         (req_o),
        .req_rnw_o     (req_rnw_o),
        .req_addr_o    (req_addr_o),
        .req_wdata_o   (req_wdata_o),
        .req_ready_i   (req_ready_i),
        .req_rdata_i   (req_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rnw_o     (rsp_rnw_o),
        .rsp_addr_o    (rsp_addr_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rnw;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        req_q[$];
    txn_t        rsp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [16];
    logic [31:0] slave_mem [16];
    int          slave_mode = 0;
    int          fix_dly    = 0;
    bit          rand_dly   = 1'b0;
    bit          mon_en     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic rnw, input logic [3:0] a, input logic [31:0] d);
        txn_t e;
        bit   ok;
        cmd_valid_i = 1'b1;
        cmd_rnw_i   = rnw;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept", 32'(ok), 32'd1);
        if (ok) begin
            e.rnw   = rnw;
            e.addr  = a;
            e.wdata = d;
            e.rdata = rnw ? model_mem[a] : 32'd0;
            if (!rnw) model_mem[a] = d;
            req_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
    endtask

    // Slave: mode 0 never ready, 1 always ready, 2 ready after fix/random delay.
    initial begin : slave
        bit          armed;
        int          cnt;
        logic        prev_req, prev_rdy, prev_rnw;
        logic [3:0]  prev_addr;
        logic [31:0] prev_wdata;
        armed = 1'b0; cnt = 0;
        prev_req = 1'b0; prev_rdy = 1'b0; prev_rnw = 1'b0;
        prev_addr = '0; prev_wdata = '0;
        req_ready_i = 1'b0;
        req_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (prev_req && prev_rdy) begin
                armed = 1'b0;
                if (!prev_rnw) slave_mem[prev_addr] = prev_wdata;
            end
            if (rst || !req_o) armed = 1'b0;
            if (req_o && !armed) begin
                armed = 1'b1;
                cnt   = rand_dly ? int'($urandom_range(0, 7)) : fix_dly;
            end
            case (slave_mode)
                1: req_ready_i = armed;
                2: begin
                    if (armed && cnt == 0) begin
                        req_ready_i = 1'b1;
                    end else begin
                        req_ready_i = 1'b0;
                        if (cnt > 0) cnt--;
                    end
                end
                default: req_ready_i = 1'b0;
            endcase
            req_rdata_i = (req_ready_i && req_rnw_o) ? slave_mem[req_addr_o] : $urandom;
            prev_req   = req_o;
            prev_rdy   = req_ready_i;
            prev_rnw   = req_rnw_o;
            prev_addr  = req_addr_o;
            prev_wdata = req_wdata_o;
        end
    end

    // Monitor: request ordering/stability, response scoreboard, timeout model.
    initial begin : monitor
        logic        prev_hs, prev_stall, p_rnw;
        logic [3:0]  p_addr;
        logic [31:0] p_wdata;
        int          exp_wait;
        logic        exp_err;
        txn_t        e;
        prev_hs = 1'b0; prev_stall = 1'b0; p_rnw = 1'b0; p_addr = '0; p_wdata = '0;
        exp_wait = 0; exp_err = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_hs) begin
                    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
                    chk("rsp_q_nonempty", 32'(rsp_q.size() != 0), 32'd1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        chk("rsp_rnw", 32'(rsp_rnw_o), 32'(e.rnw));
                        chk("rsp_addr", 32'(rsp_addr_o), 32'(e.addr));
                        chk("rsp_rdata", rsp_rdata_o, e.rdata);
                    end
                end else begin
                    chk("rsp_valid_idle", 32'(rsp_valid_o), 32'd0);
                end
                if (prev_stall) begin
                    chk("req_held", 32'(req_o), 32'd1);
                    chk("req_rnw_stable", 32'(req_rnw_o), 32'(p_rnw));
                    chk("req_addr_stable", 32'(req_addr_o), 32'(p_addr));
                    chk("req_wdata_stable", req_wdata_o, p_wdata);
                end
                chk("err_timeout", 32'(err_timeout_o), 32'(exp_err));
                if (!rst && req_o && req_ready_i) begin
                    chk("req_q_nonempty", 32'(req_q.size() != 0), 32'd1);
                    if (req_q.size() != 0) begin
                        e = req_q.pop_front();
                        chk("req_rnw", 32'(req_rnw_o), 32'(e.rnw));
                        chk("req_addr", 32'(req_addr_o), 32'(e.addr));
                        if (!e.rnw) chk("req_wdata", req_wdata_o, e.wdata);
                        rsp_q.push_back(e);
                    end
                end
                if (rst) begin
                    exp_wait = 0;
                    exp_err  = 1'b0;
                end else if (req_o && !req_ready_i) begin
                    if (exp_wait < TMO) exp_wait++;
                    if (exp_wait == TMO) exp_err = 1'b1;
                end else begin
                    exp_wait = 0;
                end
            end
            prev_hs    = mon_en && !rst && req_o && req_ready_i;
            prev_stall = mon_en && !rst && req_o && !req_ready_i;
            p_rnw      = req_rnw_o;
            p_addr     = req_addr_o;
            p_wdata    = req_wdata_o;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int hi;
        rst = 1'b1;
        cmd_valid_i = 1'b0; cmd_rnw_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = 32'd0;
            slave_mem[i] = 32'd0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_o", 32'(req_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_err", 32'(err_timeout_o), 32'd0);
        chk("rst_cmd_ready_forced", 32'(cmd_ready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Write 0xDEADBEEF to addr 3, slave ready after 2 wait cycles
        slave_mode = 2; fix_dly = 2; rand_dly = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 4'd3, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_latency_t1", 32'(req_o), 32'd0);
        @(negedge clk);
        chk("t1_latency_t2", 32'(req_o), 32'd1);
        hi = 1;
        for (int i = 0; i < 20 && req_o; i++) begin
            @(negedge clk);
            if (req_o) hi++;
        end
        chk("t1_req_cycles", 32'(hi), 32'd3);
        chk("t1_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("t1_rsp_rnw", 32'(rsp_rnw_o), 32'd0);
        chk("t1_rsp_addr", 32'(rsp_addr_o), 32'd3);
        chk("t1_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("t1_busy", 32'(busy_o), 32'd0);

        // Read addr 3 back
        fix_dly = 1;
        @(posedge clk); #1;
        send(1'b1, 4'd3, $urandom);
        for (int i = 0; i < 20 && !rsp_valid_o; i++) @(negedge clk);
        chk("t2_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("t2_rsp_rnw", 32'(rsp_rnw_o), 32'd1);
        chk("t2_rsp_addr", 32'(rsp_addr_o), 32'd3);
        chk("t2_rsp_rdata", rsp_rdata_o, 32'hDEADBEEF);

        // Stalled slave: fill FIFO plus in-flight request, then time out
        @(negedge clk);
        slave_mode = 0;
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH + 1; i++) send(1'b0, 4'(i), $urandom);
        @(negedge clk);
        chk("t3_cmd_ready_full", 32'(cmd_ready_o), 32'd0);
        chk("t3_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_rnw_i = 1'b0; cmd_addr_i = 4'd9; cmd_wdata_i = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_sixth_refused", 32'(cmd_ready_o), 32'd0);
        end
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 400 && !err_timeout_o; i++) @(negedge clk);
        chk("t3_err_set", 32'(err_timeout_o), 32'd1);
        chk("t3_req_still_up", 32'(req_o), 32'd1);
        chk("t3_req_addr", 32'(req_addr_o), 32'd0);

        // Slave goes always-ready: drain back to back
        slave_mode = 1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!req_o) break;
            hi++;
        end
        chk("t4_b2b_cycles", 32'(hi), 32'(DEPTH + 1));
        chk("t4_err_sticky", 32'(err_timeout_o), 32'd1);
        chk("t4_busy", 32'(busy_o), 32'd0);

        // Random traffic against the reference memory
        slave_mode = 2; rand_dly = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
        for (int i = 0; i < 200 && (busy_o || req_o); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("t5_drained", 32'(busy_o), 32'd0);
        chk("t5_req_q_empty", 32'(req_q.size()), 32'd0);
        chk("t5_rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        // Reset mid-REQ with two commands queued
        slave_mode = 0; rand_dly = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send(1'b1, 4'(i + 5), 32'd0);
        @(negedge clk);
        chk("t6_req_up", 32'(req_o), 32'd1);
        chk("t6_busy", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cmd_ready_in_rst", 32'(cmd_ready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_q.delete();
        rsp_q.delete();
        @(negedge clk);
        chk("t6_req_dropped", 32'(req_o), 32'd0);
        chk("t6_busy_clear", 32'(busy_o), 32'd0);
        chk("t6_no_rsp", 32'(rsp_valid_o), 32'd0);
        chk("t6_err_clear", 32'(err_timeout_o), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_stays_idle", 32'(req_o), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
